rv32_mod_fetch_aligner: RTL and testbench

Instruction-fetch front end of the rv32imc_ss core and the producer side of the instruction decoder's input. It fetches aligned 32-bit words from instruction memory and re-aligns them into a stream of instructions. Each instruction is either a 16-bit compressed one, zero-extended, or a 32-bit one, including one that straddles a word boundary. Each instruction is tagged with its PC and a compressed flag, and transfers to the decode stage over a valid/ready handshake. A redirect input (branch, jump, trap) flushes the stream and restarts fetch at a halfword-aligned PC.

---
 rtl/rv32_pkg.sv | 23 ++
 rtl/rv32_mod_halfword_queue.sv | 81 ++++++++
 rtl/rv32_mod_fetch_aligner.sv | 177 +++++++++++++++++
 tb/tb_rv32_mod_fetch_aligner.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// ----------------------------------------------------------------------------
// rv32_pkg
// Shared types and helpers for the rv32imc_ss instruction-fetch front end.
//   fetch_state_t     : fetch request state machine encoding
//   QUEUE_DEPTH       : number of 16-bit entries in the halfword queue
//   is_compressed_hw  : classifies a head halfword as a 16-bit instruction
// ----------------------------------------------------------------------------
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        WAIT         = 2'd1,
        WAIT_DISCARD = 2'd2
    } fetch_state_t;

    localparam int QUEUE_DEPTH = 3;

    // A halfword starts a compressed instruction unless its two low bits are 11.
    function automatic logic is_compressed_hw(input logic [15:0] hw);
        return (hw & 16'h0003) != 16'h0003;
    endfunction

endpackage

// File: rtl/rv32_mod_halfword_queue.sv
// ----------------------------------------------------------------------------
// rv32_mod_halfword_queue
// Three-entry shift queue of 16-bit instruction halfwords. Entry 0 is the
// head. Each cycle up to two entries are popped from the head and up to two
// entries are appended behind whatever survives the pop. Flush empties it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset (count only)
//   flush               : drop all entries this cycle
//   push_num            : 0, 1 or 2 halfwords to append
//   push_hw0, push_hw1  : halfwords to append, hw0 first
//   pop_num             : 0, 1 or 2 halfwords to remove from the head
//   entry0, entry1      : head and second entry
//   count               : number of valid entries (0..3)
// ----------------------------------------------------------------------------
module rv32_mod_halfword_queue
    import rv32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic [1:0]  push_num,
    input  logic [15:0] push_hw0,
    input  logic [15:0] push_hw1,
    input  logic [1:0]  pop_num,
    output logic [15:0] entry0,
    output logic [15:0] entry1,
    output logic [1:0]  count
);

    logic [15:0] q       [QUEUE_DEPTH];
    logic [15:0] shifted [QUEUE_DEPTH];
    logic [15:0] q_next  [QUEUE_DEPTH];
    logic [1:0]  remain;
    logic [1:0]  count_next;

    always_comb begin
        // The producer never pops more than count, so this cannot underflow.
        remain = count - pop_num;

        case (pop_num)
            2'd1:    shifted = '{q[1], q[2], q[2]};
            2'd2:    shifted = '{q[2], q[2], q[2]};
            default: shifted = q;
        endcase

        // New halfwords land directly behind the surviving entries; slots
        // beyond the new count keep stale data that nobody reads.
        q_next = shifted;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (push_num != 2'd0 && i == int'(remain)) begin
                q_next[i] = push_hw0;
            end
            if (push_num == 2'd2 && i == int'(remain) + 1) begin
                q_next[i] = push_hw1;
            end
        end

        if (flush) begin
            count_next = 2'd0;
        end else begin
            count_next = remain + push_num;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
        end else begin
            count <= count_next;
        end
    end

    // Entry storage carries no reset: validity is defined by count alone.
    always_ff @(posedge clk) begin
        q <= q_next;
    end

    assign entry0 = q[0];
    assign entry1 = q[1];

endmodule

// File: rtl/rv32_mod_fetch_aligner.sv
// ----------------------------------------------------------------------------
// rv32_mod_fetch_aligner
// Instruction-fetch front end. Fetches aligned 32-bit words, splits them into
// halfwords in a small queue and presents one instruction at a time (16-bit
// compressed, zero-extended, or 32-bit, possibly straddling two words) to the
// decoder over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch at a halfword-aligned PC.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   redirect_valid/_pc    : flush and restart at redirect_pc (bit 0 ignored)
//   mem_req/mem_addr      : word fetch request, held until mem_ack
//   mem_ack/mem_rdata     : fetched word, little-endian halfwords
//   instr_valid/_ready    : decode handshake
//   instruction           : 32-bit instruction or {16'h0, halfword}
//   instr_pc              : byte address of the instruction
//   instr_is_compressed   : head halfword is a 16-bit instruction
// ----------------------------------------------------------------------------
module rv32_mod_fetch_aligner
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    output logic        instr_is_compressed
);

    localparam logic [31:0] RESET_WORD = RESET_PC & 32'hFFFF_FFFC;
    localparam logic [31:0] RESET_HEAD = RESET_PC & 32'hFFFF_FFFE;
    localparam logic        RESET_DROP = RESET_PC[1];

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  head_pc;
    logic         drop_first;

    logic [15:0]  entry0;
    logic [15:0]  entry1;
    logic [1:0]   count;
    logic         head_compressed;
    logic         transfer;
    logic         data_accept;
    logic [1:0]   push_num;
    logic [1:0]   pop_num;
    logic [15:0]  push_hw0;
    logic [2:0]   count_next;
    logic [31:0]  redir_word;
    logic [31:0]  redir_head;

    assign redir_word = redirect_pc & 32'hFFFF_FFFC;
    assign redir_head = redirect_pc & 32'hFFFF_FFFE;

    // Decode-side view: purely combinational from the queue registers.
    assign head_compressed     = is_compressed_hw(entry0);
    assign instr_valid         = (count != 2'd0 && head_compressed) || (count >= 2'd2);
    assign instr_is_compressed = (count != 2'd0) && head_compressed;
    assign instr_pc            = head_pc;
    assign instruction         = !instr_valid    ? 32'h0000_0000 :
                                 head_compressed ? {16'h0000, entry0} :
                                                   {entry1, entry0};

    // A redirect voids any handshake that coincides with it.
    assign transfer = instr_valid && instr_ready && !redirect_valid;
    assign pop_num  = !transfer ? 2'd0 : (head_compressed ? 2'd1 : 2'd2);

    // Only an ack for a live (non-discarded) request delivers halfwords. After
    // a redirect to an upper halfword the first word's low half is skipped.
    assign data_accept = (state == WAIT) && mem_ack && !redirect_valid;
    assign push_num    = !data_accept ? 2'd0 : (drop_first ? 2'd1 : 2'd2);
    assign push_hw0    = drop_first ? mem_rdata[31:16] : mem_rdata[15:0];

    assign count_next = redirect_valid ? 3'd0
                      : ({1'b0, count} + {1'b0, push_num} - {1'b0, pop_num});

    rv32_mod_halfword_queue u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (redirect_valid),
        .push_num (push_num),
        .push_hw0 (push_hw0),
        .push_hw1 (mem_rdata[31:16]),
        .pop_num  (pop_num),
        .entry0   (entry0),
        .entry1   (entry1),
        .count    (count)
    );

    // Fetch state machine. A new word is requested only when at most one
    // halfword will remain, so two more always fit in the three-entry queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= RESET_WORD;
            fetch_pc   <= RESET_WORD;
            head_pc    <= RESET_HEAD;
            drop_first <= RESET_DROP;
        end else if (redirect_valid) begin
            head_pc    <= redir_head;
            fetch_pc   <= redir_word;
            drop_first <= redirect_pc[1];
            case (state)
                IDLE: begin
                    state    <= WAIT;
                    mem_req  <= 1'b1;
                    mem_addr <= redir_word;
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_addr <= redir_word;
                    end else begin
                        // The outstanding request must complete unchanged.
                        state <= WAIT_DISCARD;
                    end
                end
                WAIT_DISCARD: begin
                    if (mem_ack) begin
                        state    <= WAIT;
                        mem_addr <= redir_word;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end else begin
            if (transfer) begin
                head_pc <= head_pc + (head_compressed ? 32'd2 : 32'd4);
            end
            case (state)
                IDLE: begin
                    if (count_next <= 3'd1) begin
                        state    <= WAIT;
                        mem_req  <= 1'b1;
                        mem_addr <= fetch_pc;
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        drop_first <= 1'b0;
                        fetch_pc   <= fetch_pc + 32'd4;
                        if (count_next <= 3'd1) begin
                            mem_addr <= fetch_pc + 32'd4;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end
                end
                WAIT_DISCARD: begin
                    // Stale word is dropped; fetch_pc already holds the target.
                    if (mem_ack) begin
                        state    <= WAIT;
                        mem_addr <= fetch_pc;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32_mod_fetch_aligner.sv
module tb_rv32_mod_fetch_aligner;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_is_compressed;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mem [0:255];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    logic [31:0] req_log [$];
    logic [31:0] obs_pc  [$];
    logic [31:0] obs_ins [$];
    logic        obs_c   [$];

    rv32_mod_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .mem_req             (mem_req),
        .mem_addr            (mem_addr),
        .mem_ack             (mem_ack),
        .mem_rdata           (mem_rdata),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instruction         (instruction),
        .instr_pc            (instr_pc),
        .instr_is_compressed (instr_is_compressed)
    );

    always #5 clk = ~clk;

    // Memory responder: ack after ack_delay wait cycles, driven on negedge.
    always @(negedge clk) begin
        if (mem_ack) wait_cnt = 0;
        mem_ack = 1'b0;
        if (rst_n && mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr[9:2]];
                req_log.push_back(mem_addr);
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Transfer monitor: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
            obs_pc.push_back(instr_pc);
            obs_ins.push_back(instruction);
            obs_c.push_back(instr_is_compressed);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [15:0] chw(input int pc);
        return 16'((pc << 4) | 1);
    endfunction

    task automatic fill_default();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        redirect_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_obs(input string tag, input int need, input int budget);
        int c = 0;
        while (obs_pc.size() < need && c < budget) begin
            @(posedge clk);
            c++;
        end
        #1;
        if (obs_pc.size() < need) chk({tag, "_timeout"}, obs_pc.size(), need);
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [31:0] pc,
                             input logic [31:0] ins, input logic c);
        if (idx < obs_pc.size()) begin
            chk({tag, "_pc"}, obs_pc[idx], pc);
            chk({tag, "_ins"}, obs_ins[idx], ins);
            chk({tag, "_c"}, {31'b0, obs_c[idx]}, {31'b0, c});
        end else begin
            chk({tag, "_missing"}, obs_pc.size(), idx + 1);
        end
    endtask

    task automatic check_req(input string tag, input int idx, input logic [31:0] addr);
        if (idx < req_log.size()) chk(tag, req_log[idx], addr);
        else chk({tag, "_missing"}, req_log.size(), idx + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    initial begin
        int ob;
        int rb;
        int c;

        // Reset values and sequential full instructions
        fill_default();
        ack_delay   = 0;
        instr_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_comp", {31'b0, instr_is_compressed}, 32'd0);
        ob = obs_pc.size();
        rb = req_log.size();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(1);
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        wait_obs("seq", ob + 3, 40);
        check_obs("seq0", ob + 0, 32'h0, 32'h0000_0013, 1'b0);
        check_obs("seq1", ob + 1, 32'h4, 32'h0000_0013, 1'b0);
        check_obs("seq2", ob + 2, 32'h8, 32'h0000_0013, 1'b0);
        check_req("seq_req0", rb + 0, 32'h0);
        check_req("seq_req1", rb + 1, 32'h4);
        check_req("seq_req2", rb + 2, 32'h8);

        // Mixed compressed and straddling, slow memory
        fill_default();
        mem[0] = 32'h0013_4501;
        mem[1] = 32'h0000_0000;
        ack_delay = 3;
        do_reset();
        ob = obs_pc.size();
        c = 0;
        while (!(mem_req && mem_addr == 32'h4) && c < 60) begin
            tick(1);
            c++;
        end
        chk("strad_req_addr", mem_addr, 32'h4);
        chk("strad_hold_valid", {31'b0, instr_valid}, 32'd0);
        chk("strad_hold_pc", instr_pc, 32'h2);
        wait_obs("mix", ob + 3, 60);
        check_obs("mix0", ob + 0, 32'h0, 32'h0000_4501, 1'b1);
        check_obs("mix1", ob + 1, 32'h2, 32'h0000_0013, 1'b0);
        check_obs("mix2", ob + 2, 32'h6, 32'h0000_0000, 1'b1);

        // Redirect to a halfword-aligned PC
        fill_default();
        mem[32'h100 >> 2] = 32'h4501_FFFF;
        ack_delay = 0;
        do_reset();
        tick(6);
        redirect_pc    = 32'h0000_0102;
        redirect_valid = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        ob = obs_pc.size();
        rb = req_log.size();
        chk("redir_req", {31'b0, mem_req}, 32'd1);
        chk("redir_addr", mem_addr, 32'h100);
        wait_obs("redir", ob + 2, 40);
        check_obs("redir0", ob + 0, 32'h102, 32'h0000_4501, 1'b1);
        check_obs("redir1", ob + 1, 32'h104, 32'h0000_0013, 1'b0);
        check_req("redir_req0", rb, 32'h100);

        // Redirect while a request is outstanding
        fill_default();
        mem[2]              = 32'hDEAD_BEEF;
        mem[32'h200 >> 2]   = 32'h00A0_0093;
        ack_delay = 3;
        do_reset();
        c = 0;
        while (!(mem_req && mem_addr == 32'h8) && c < 60) begin
            tick(1);
            c++;
        end
        redirect_pc    = 32'h0000_0200;
        redirect_valid = 1'b1;
        tick(1);
        redirect_valid = 1'b0;
        ob = obs_pc.size();
        rb = req_log.size();
        chk("disc_addr0", mem_addr, 32'h8);
        tick(1);
        chk("disc_addr1", mem_addr, 32'h8);
        tick(1);
        chk("disc_addr2", mem_addr, 32'h8);
        wait_obs("disc", ob + 1, 40);
        check_obs("disc0", ob, 32'h200, 32'h00A0_0093, 1'b0);
        check_req("disc_req0", rb + 0, 32'h8);
        check_req("disc_req1", rb + 1, 32'h200);

        // Backpressure with compressed-only code
        for (int i = 0; i < 256; i++) mem[i] = {chw(4 * i + 2), chw(4 * i)};
        ack_delay   = 0;
        instr_ready = 1'b0;
        do_reset();
        tick(3);
        for (int i = 0; i < 10; i++) begin
            chk("bp_req", {31'b0, mem_req}, 32'd0);
            chk("bp_valid", {31'b0, instr_valid}, 32'd1);
            chk("bp_pc", instr_pc, 32'h0);
            chk("bp_ins", instruction, {16'h0, chw(0)});
            tick(1);
        end
        ob = obs_pc.size();
        instr_ready = 1'b1;
        wait_obs("bp", ob + 6, 60);
        for (int k = 0; k < 6; k++) begin
            check_obs("bp_out", ob + k, 32'(2 * k), {16'h0, chw(2 * k)}, 1'b1);
        end

        // Asynchronous reset mid-stream
        fill_default();
        ack_delay = 3;
        do_reset();
        ob = obs_pc.size();
        c = 0;
        while (!(mem_req && obs_pc.size() > ob) && c < 60) begin
            tick(1);
            c++;
        end
        chk("ar_pre_req", {31'b0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_mem_req", {31'b0, mem_req}, 32'd0);
        chk("ar_valid", {31'b0, instr_valid}, 32'd0);
        chk("ar_instr", instruction, 32'h0);
        chk("ar_pc", instr_pc, 32'h0);
        ob = obs_pc.size();
        rb = req_log.size();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_obs("ar", ob + 1, 40);
        check_obs("ar0", ob, 32'h0, 32'h0000_0013, 1'b0);
        check_req("ar_req0", rb, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
